dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store unit between the pipeline memory stage and the single-port synchronous data SRAM.
- The SRAM is word-wide, active-low CSN, WEN high = read and low = write, with a registered read output. It has no byte enables.
- This block converts byte, halfword and word loads/stores into SRAM cycles. Sub-word stores use read-modify-write.
- Load data is sign- or zero-extended and returned with a one-cycle ACK pulse. Misaligned accesses are flagged without touching memory.

Parameters:
- AW, 10, SRAM word-address width; byte address space is 4*2^AW.

Ports:
- CLK  in  1  clock; all state on posedge.
- RST  in  1  asynchronous, active-high reset.
- REQ  in  1  access request; sampled only when BUSY=0.
- WE  in  1  1=store, 0=load.
- SIZE  in  2  00=byte, 01=half, 10=word, 11=illegal.
- UNSIGNED  in  1  loads: 1=zero-extend, 0=sign-extend.
- ADDR  in  32  byte address.
- WDATA  in  32  store data, right-justified.
- BUSY  out  1  1 whenever state is not IDLE.
- ACK  out  1  one-cycle completion pulse (registered).
- ERR  out  1  one-cycle pulse coincident with ACK for misaligned/illegal requests.
- RDATA  out  32  extended load result; registered, held until the next load completes.
- MEM_CSN  out  1  SRAM chip select, active low.
- MEM_WEN  out  1  SRAM write enable (0=write).
- MEM_A  out  AW  SRAM word address = latched ADDR[AW+1:2].
- MEM_DI  out  32  SRAM write data.
- MEM_DOUT  in  32  SRAM read data, valid from one edge after the read edge.

Behaviour:
- States: IDLE, RD, RDW, WR.
- Reset (async): state=IDLE; ACK=0, ERR=0, RDATA=0, merge register=0, latched request fields=0.
- MEM_CSN, MEM_WEN and MEM_DI are decoded combinationally from state, so reset forces MEM_CSN=1 and MEM_WEN=1 immediately.
- Reset asserted during WR suppresses the write: no partial store. Any in-flight access is dropped and no ACK is issued.
- Accept rule: REQ=1 in IDLE at edge E0 latches WE, SIZE, UNSIGNED, ADDR and WDATA. REQ in other states is ignored.
- A request is accepted in the ACK cycle, since state is IDLE then, giving back-to-back throughput.
- Misaligned or illegal request:
  - Condition: SIZE=11, SIZE=01 with ADDR[0]=1, or SIZE=10 with ADDR[1:0]!=0.
  - State stays IDLE with no SRAM cycle; ACK=ERR=1 in the cycle after E0; RDATA is unchanged.
- Word store: E0 -> WR.
  - WR drives MEM_CSN=0, MEM_WEN=0, MEM_DI=WDATA.
  - E1 writes the SRAM and moves to IDLE; ACK is high in the cycle after E1.
- Load: E0 -> RD.
  - RD drives MEM_CSN=0, MEM_WEN=1; E1 moves to RDW.
  - RDW drives MEM_CSN=1; E2 registers the extracted MEM_DOUT into RDATA and moves to IDLE.
  - ACK is high in the cycle after E2.
- Sub-word store: E0 -> RD, E1 -> RDW.
  - At E2 the merge register = MEM_DOUT with the target lane(s) replaced; state -> WR.
  - WR drives MEM_DI=merge; E3 writes and moves to IDLE; ACK is high in the cycle after E3.
- Lanes are little-endian: byte n = bits 8n+7:8n, selected by ADDR[1:0].
  - Half lane is ADDR[1] (0 -> bits 15:0, 1 -> bits 31:16).
  - Store uses WDATA[7:0] or WDATA[15:0]; upper WDATA bits are ignored.
- Load extension: byte/half is sign-extended from its MSB when UNSIGNED=0 and zero-extended otherwise. Word loads ignore UNSIGNED.
- Address wrap: ADDR bits above AW+1 are ignored (aliasing modulo 4*2^AW bytes).
- In IDLE, RDW and RST: MEM_CSN=1, MEM_WEN=1. MEM_A always reflects the latched address.
- ACK/ERR are never high for more than one cycle per request. Stores never modify RDATA.

Test Plan:
- Word store 0x11223344 at 0x10, then word load at 0x10 -> SRAM word 4 = 0x11223344; store ACK at E0+1 cycle; load ACK at E0+2 cycles with RDATA=0x11223344.
- Byte store WDATA=0xFFFFFFAB at 0x12 onto 0x11223344 -> MEM_WEN low exactly once, at E3; word 4 = 0x11AB3344; ACK after E3.
- With word 4 = 0x11AB3344:
  - Signed byte load at 0x12 -> RDATA=0xFFFFFFAB.
  - Unsigned byte load at 0x12 -> RDATA=0x000000AB.
  - Signed half load at 0x12 -> RDATA=0x000011AB.
- Half load at 0x13, word store at 0x02 and SIZE=11 -> ERR=ACK=1 one cycle after accept; MEM_CSN stays 1; RDATA and memory unchanged.
- REQ held high for a load then a store -> second request accepted on the ACK cycle; REQ pulses while BUSY=1 are ignored (exactly one ACK each).
- RST pulse while in WR of a byte-store RMW -> MEM_CSN goes to 1 immediately; memory word unchanged; no ACK; outputs at reset values; next request completes normally.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store unit between the memory stage and a single-port word SRAM.
// Sub-word stores are read-modify-write; loads are extended and ACKed.
module dmem_lsu #(
   parameter int AW = 10
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          REQ,
   input  logic          WE,
   input  logic [1:0]    SIZE,
   input  logic          UNSIGNED,
   input  logic [31:0]   ADDR,
   input  logic [31:0]   WDATA,
   output logic          BUSY,
   output logic          ACK,
   output logic          ERR,
   output logic [31:0]   RDATA,
   output logic          MEM_CSN,
   output logic          MEM_WEN,
   output logic [AW-1:0] MEM_A,
   output logic [31:0]   MEM_DI,
   input  logic [31:0]   MEM_DOUT
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_RDW,
      S_WR
   } state_t;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   state_t        r_state;
   state_t        w_next;

   logic          r_we;
   logic [1:0]    r_size;
   logic          r_uns;
   logic [AW+1:0] r_addr;
   logic [31:0]   r_wdata;
   logic [31:0]   r_merge;
   logic          r_ack;
   logic          r_err;
   logic [31:0]   r_rdata;

   logic          w_accept;
   logic          w_misalign;
   logic          w_ack_nxt;
   logic          w_err_nxt;
   logic          w_csn;
   logic          w_wen;
   logic [31:0]   w_di;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_load;
   logic [31:0]   w_merge;
   logic          w_unused;

   // Address bits above the SRAM range alias and are deliberately dropped.
   assign w_unused = ^ADDR[31:AW+2];

   assign w_accept = (r_state == S_IDLE) && REQ;

   assign w_misalign = (SIZE == 2'b11)
                    || ((SIZE == SZ_H) && ADDR[0])
                    || ((SIZE == SZ_W) && (ADDR[1:0] != 2'b00));

   // Select the addressed byte lane of the returned word.
   always_comb begin
      w_byte = MEM_DOUT[7:0];
      unique case (r_addr[1:0])
         2'b00: w_byte = MEM_DOUT[7:0];
         2'b01: w_byte = MEM_DOUT[15:8];
         2'b10: w_byte = MEM_DOUT[23:16];
         2'b11: w_byte = MEM_DOUT[31:24];
      endcase
   end

   assign w_half = r_addr[1] ? MEM_DOUT[31:16] : MEM_DOUT[15:0];

   // Sign- or zero-extend the selected lane; words pass through.
   always_comb begin
      w_load = MEM_DOUT;
      if (r_size == SZ_B) begin
         w_load = {{24{~r_uns & w_byte[7]}}, w_byte};
      end else if (r_size == SZ_H) begin
         w_load = {{16{~r_uns & w_half[15]}}, w_half};
      end
   end

   // Replace the target lane(s) of the read word with store data.
   always_comb begin
      w_merge = MEM_DOUT;
      if (r_size == SZ_B) begin
         unique case (r_addr[1:0])
            2'b00: w_merge[7:0]   = r_wdata[7:0];
            2'b01: w_merge[15:8]  = r_wdata[7:0];
            2'b10: w_merge[23:16] = r_wdata[7:0];
            2'b11: w_merge[31:24] = r_wdata[7:0];
         endcase
      end else if (r_size == SZ_H) begin
         if (r_addr[1]) begin
            w_merge[31:16] = r_wdata[15:0];
         end else begin
            w_merge[15:0] = r_wdata[15:0];
         end
      end
   end

   // Next state, completion strobes and SRAM controls from state.
   always_comb begin
      w_next    = r_state;
      w_ack_nxt = 1'b0;
      w_err_nxt = 1'b0;
      w_csn     = 1'b1;
      w_wen     = 1'b1;
      w_di      = '0;
      unique case (r_state)
         S_IDLE: begin
            if (REQ) begin
               if (w_misalign) begin
                  w_ack_nxt = 1'b1;
                  w_err_nxt = 1'b1;
               end else if (WE && (SIZE == SZ_W)) begin
                  w_next = S_WR;
               end else begin
                  w_next = S_RD;
               end
            end
         end
         S_RD: begin
            w_csn  = 1'b0;
            w_next = S_RDW;
         end
         S_RDW: begin
            if (r_we) begin
               w_next = S_WR;
            end else begin
               w_next    = S_IDLE;
               w_ack_nxt = 1'b1;
            end
         end
         S_WR: begin
            w_csn     = 1'b0;
            w_wen     = 1'b0;
            w_di      = (r_size == SZ_W) ? r_wdata : r_merge;
            w_next    = S_IDLE;
            w_ack_nxt = 1'b1;
         end
      endcase
   end

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Capture the request fields when a request is taken in IDLE.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_we    <= 1'b0;
         r_size  <= 2'b00;
         r_uns   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_we    <= WE;
         r_size  <= SIZE;
         r_uns   <= UNSIGNED;
         r_addr  <= ADDR[AW+1:0];
         r_wdata <= WDATA;
      end
   end

   // Completion strobes, load result and RMW merge word.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
         r_merge <= '0;
      end else begin
         r_ack <= w_ack_nxt;
         r_err <= w_err_nxt;
         if ((r_state == S_RDW) && !r_we) begin
            r_rdata <= w_load;
         end
         if ((r_state == S_RDW) && r_we) begin
            r_merge <= w_merge;
         end
      end
   end

   assign BUSY    = (r_state != S_IDLE);
   assign ACK     = r_ack;
   assign ERR     = r_err;
   assign RDATA   = r_rdata;
   assign MEM_CSN = w_csn;
   assign MEM_WEN = w_wen;
   assign MEM_A   = r_addr[AW+1:2];
   assign MEM_DI  = w_di;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: SRAM model, transaction-level reference model,
// per-cycle compare and directed literal checks.
module tb_dmem_lsu;

   logic        CLK;
   logic        RST;
   logic        REQ;
   logic        WE;
   logic [1:0]  SIZE;
   logic        UNSIGNED;
   logic [31:0] ADDR;
   logic [31:0] WDATA;
   logic        BUSY;
   logic        ACK;
   logic        ERR;
   logic [31:0] RDATA;
   logic        MEM_CSN;
   logic        MEM_WEN;
   logic [9:0]  MEM_A;
   logic [31:0] MEM_DI;
   logic [31:0] MEM_DOUT;

   dmem_lsu #(.AW(10)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .SIZE(SIZE),
      .UNSIGNED(UNSIGNED), .ADDR(ADDR), .WDATA(WDATA), .BUSY(BUSY),
      .ACK(ACK), .ERR(ERR), .RDATA(RDATA), .MEM_CSN(MEM_CSN),
      .MEM_WEN(MEM_WEN), .MEM_A(MEM_A), .MEM_DI(MEM_DI),
      .MEM_DOUT(MEM_DOUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [31:0] sram [0:1023];
   logic [31:0] mdl  [0:1023];

   // Synchronous SRAM with registered read data.
   always @(posedge CLK) begin
      if (!MEM_CSN) begin
         if (!MEM_WEN) sram[MEM_A] <= MEM_DI;
         else MEM_DOUT <= sram[MEM_A];
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: transaction level, latency per request kind.
   int          n = 0;
   bit          pend = 0;
   int          done = 0;
   int          acc_edge = 0;
   int          ack_edge = 0;
   int          acc_cnt = 0;
   int          wr_cnt = 0;
   int          wr_edge = 0;
   bit          p_we;
   logic [1:0]  p_size;
   bit          p_uns;
   logic [31:0] p_addr;
   logic [31:0] p_wd;
   logic        m_ack = 0;
   logic        m_err = 0;
   logic [31:0] m_rdata = 0;

   function automatic logic [31:0] lane_mask(input logic [1:0] sz);
      if (sz == 2'b00) return 32'h0000_00FF;
      if (sz == 2'b01) return 32'h0000_FFFF;
      return 32'hFFFF_FFFF;
   endfunction

   function automatic int lane_shift(input logic [1:0] sz,
                                     input logic [31:0] a);
      if (sz == 2'b00) return 8 * int'(a[1:0]);
      if (sz == 2'b01) return 16 * int'(a[1]);
      return 0;
   endfunction

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         pend    = 0;
         m_ack   = 0;
         m_err   = 0;
         m_rdata = 0;
      end else begin
         int          idx;
         logic [31:0] w;
         logic [31:0] msk;
         int          sh;
         n++;
         if (!MEM_CSN && !MEM_WEN) begin
            wr_cnt++;
            wr_edge = n;
         end
         m_ack = 0;
         m_err = 0;
         if (pend) begin
            if (n == done) begin
               idx = int'((p_addr >> 2) % 1024);
               w   = mdl[idx];
               msk = lane_mask(p_size);
               sh  = lane_shift(p_size, p_addr);
               if (p_we) begin
                  mdl[idx] = (w & ~(msk << sh)) | ((p_wd & msk) << sh);
               end else begin
                  m_rdata = (w >> sh) & msk;
                  if (!p_uns && p_size == 2'b00 && m_rdata[7])
                     m_rdata = m_rdata | 32'hFFFF_FF00;
                  if (!p_uns && p_size == 2'b01 && m_rdata[15])
                     m_rdata = m_rdata | 32'hFFFF_0000;
               end
               m_ack    = 1;
               ack_edge = n;
               pend     = 0;
            end
         end else if (REQ) begin
            acc_cnt++;
            acc_edge = n;
            p_we   = WE;
            p_size = SIZE;
            p_uns  = UNSIGNED;
            p_addr = ADDR;
            p_wd   = WDATA;
            if (SIZE == 2'b11 || (SIZE == 2'b01 && ADDR[0])
                || (SIZE == 2'b10 && ADDR[1:0] != 2'b00)) begin
               m_ack    = 1;
               m_err    = 1;
               ack_edge = n;
            end else begin
               pend = 1;
               if (WE && SIZE == 2'b10) done = n + 1;
               else if (WE) done = n + 3;
               else done = n + 2;
            end
         end
      end
   end

   int dut_ack = 0;
   int dut_err = 0;

   // Per-cycle compare against the model.
   always @(negedge CLK) begin
      if (!RST) begin
         chk("ack", {31'b0, ACK}, {31'b0, m_ack});
         chk("err", {31'b0, ERR}, {31'b0, m_err});
         chk("rdata", RDATA, m_rdata);
         chk("busy", {31'b0, BUSY}, {31'b0, pend});
         if (!pend) chk("csn_idle", {31'b0, MEM_CSN}, 32'd1);
         if (ACK) dut_ack++;
         if (ERR) dut_err++;
      end
   end

   task automatic wait_acc(input int c0);
      int k = 0;
      while (acc_cnt == c0 && k < 20) begin
         @(posedge CLK);
         #1;
         k++;
      end
      if (acc_cnt == c0) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_req(input bit we, input logic [1:0] sz,
                         input bit un, input logic [31:0] a,
                         input logic [31:0] wd);
      int c0;
      @(negedge CLK);
      WE = we; SIZE = sz; UNSIGNED = un; ADDR = a; WDATA = wd;
      c0 = acc_cnt;
      REQ = 1'b1;
      wait_acc(c0);
      @(negedge CLK);
      REQ = 1'b0;
      repeat (4) @(negedge CLK);
   endtask

   int a0, e0, w0, c0;
   logic [31:0] rd0;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         sram[i] = '0;
         mdl[i]  = '0;
      end
      RST = 1'b1; REQ = 1'b0; WE = 1'b0; SIZE = 2'b00;
      UNSIGNED = 1'b0; ADDR = '0; WDATA = '0;
      #1;
      chk("rst_csn", {31'b0, MEM_CSN}, 32'd1);
      chk("rst_wen", {31'b0, MEM_WEN}, 32'd1);
      chk("rst_ack", {31'b0, ACK}, 32'd0);
      chk("rst_rdata", RDATA, 32'd0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);

      do_req(1, 2'b10, 0, 32'h10, 32'h1122_3344);
      chk("st_w_lat", ack_edge - acc_edge, 32'd1);
      chk("st_w_mem", sram[4], 32'h1122_3344);
      do_req(0, 2'b10, 0, 32'h10, 32'h0);
      chk("ld_w_lat", ack_edge - acc_edge, 32'd2);
      chk("ld_w_data", RDATA, 32'h1122_3344);

      w0 = wr_cnt;
      do_req(1, 2'b00, 0, 32'h12, 32'hFFFF_FFAB);
      chk("st_b_writes", wr_cnt - w0, 32'd1);
      chk("st_b_wedge", wr_edge - acc_edge, 32'd3);
      chk("st_b_lat", ack_edge - acc_edge, 32'd3);
      chk("st_b_mem", sram[4], 32'h11AB_3344);
      chk("st_b_rdata", RDATA, 32'h1122_3344);

      do_req(0, 2'b00, 0, 32'h12, 32'h0);
      chk("ld_sb", RDATA, 32'hFFFF_FFAB);
      do_req(0, 2'b00, 1, 32'h12, 32'h0);
      chk("ld_ub", RDATA, 32'h0000_00AB);
      do_req(0, 2'b01, 0, 32'h12, 32'h0);
      chk("ld_sh", RDATA, 32'h0000_11AB);

      e0 = dut_err; a0 = dut_ack;
      do_req(0, 2'b01, 0, 32'h13, 32'h0);
      chk("err_h_lat", ack_edge - acc_edge, 32'd0);
      do_req(1, 2'b10, 0, 32'h02, 32'hDEAD_BEEF);
      do_req(0, 2'b11, 0, 32'h10, 32'h0);
      chk("err_cnt", dut_err - e0, 32'd3);
      chk("err_ack_cnt", dut_ack - a0, 32'd3);
      chk("err_rdata", RDATA, 32'h0000_11AB);
      chk("err_mem0", sram[0], 32'h0);

      do_req(1, 2'b01, 0, 32'h16, 32'h1234_BEEF);
      chk("st_h_mem", sram[5], 32'hBEEF_0000);
      do_req(0, 2'b01, 0, 32'h16, 32'h0);
      chk("ld_sh_hi", RDATA, 32'hFFFF_BEEF);
      do_req(0, 2'b10, 0, 32'h0000_1014, 32'h0);
      chk("ld_alias", RDATA, 32'hBEEF_0000);

      // REQ held: load accepted, store taken on the load's ACK cycle.
      @(negedge CLK);
      WE = 0; SIZE = 2'b10; UNSIGNED = 0; ADDR = 32'h10; WDATA = 0;
      c0 = acc_cnt;
      REQ = 1'b1;
      wait_acc(c0);
      a0 = acc_edge;
      @(negedge CLK);
      WE = 1; ADDR = 32'h20; WDATA = 32'hCAFE_F00D;
      c0 = acc_cnt;
      wait_acc(c0);
      chk("b2b_gap", acc_edge - a0, 32'd3);
      @(negedge CLK);
      REQ = 1'b0;
      repeat (4) @(negedge CLK);
      chk("b2b_rdata", RDATA, 32'h11AB_3344);
      chk("b2b_mem", sram[8], 32'hCAFE_F00D);

      // REQ pulse while busy is ignored.
      a0 = dut_ack;
      @(negedge CLK);
      WE = 0; SIZE = 2'b10; ADDR = 32'h14;
      c0 = acc_cnt;
      REQ = 1'b1;
      wait_acc(c0);
      @(negedge CLK);
      REQ = 1'b0;
      @(negedge CLK);
      WE = 1; ADDR = 32'h30; WDATA = 32'h5A5A_5A5A;
      REQ = 1'b1;
      @(negedge CLK);
      REQ = 1'b0;
      repeat (4) @(negedge CLK);
      chk("busy_ign_ack", dut_ack - a0, 32'd1);
      chk("busy_ign_mem", sram[12], 32'h0);
      chk("busy_ld", RDATA, 32'hBEEF_0000);

      // Reset during WR of a byte-store RMW.
      a0 = dut_ack;
      @(negedge CLK);
      WE = 1; SIZE = 2'b00; UNSIGNED = 0; ADDR = 32'h12; WDATA = 32'h55;
      c0 = acc_cnt;
      REQ = 1'b1;
      wait_acc(c0);
      @(negedge CLK);
      REQ = 1'b0;
      repeat (2) @(negedge CLK);
      chk("pre_rst_wen", {31'b0, MEM_WEN}, 32'd0);
      #2 RST = 1'b1;
      #1;
      chk("rst_wr_csn", {31'b0, MEM_CSN}, 32'd1);
      chk("rst_wr_wen", {31'b0, MEM_WEN}, 32'd1);
      chk("rst_wr_busy", {31'b0, BUSY}, 32'd0);
      chk("rst_wr_rdata", RDATA, 32'd0);
      @(negedge CLK);
      #2 RST = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_wr_mem", sram[4], 32'h11AB_3344);
      chk("rst_wr_noack", dut_ack - a0, 32'd0);
      do_req(0, 2'b00, 1, 32'h13, 32'h0);
      chk("post_rst_ub", RDATA, 32'h0000_0011);
      do_req(0, 2'b10, 0, 32'h10, 32'h0);
      chk("post_rst_w", RDATA, 32'h11AB_3344);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
